// File: rtl/fmul_72bit_exception_pack.sv
// fmul_72bit_exception_pack
//   Final stage of the 72-bit FMUL pipeline. It resolves special operands
//   (zero / inf / NaN) and exponent overflow/underflow, then packs the result
//   as {sign, exp[10:0], fract[59:0]}. Results are queued in a small output
//   FIFO so that the upstream busy is driven from a register, and sticky
//   exception flags are kept.
//
// Ports
//   iCLOCK, inRESET (async, active-low), iRESET_SYNC (sync clear, active-high)
//   iDATA_VALID / oDATA_BUSY       upstream handshake (busy = FIFO full)
//   iDATA_SIGN, iDATA_EXP[12:0], iDATA_FRACT[60:0]   rounded result fields
//   iDATA_EXCEPT_*                 operand A/B exponent / fraction class bits
//   oDATA_VALID / iDATA_BUSY       downstream handshake (FIFO head)
//   oDATA_RESULT[71:0], oDATA_OVERFLOW/UNDERFLOW/INVALID   FIFO head contents
//   iSTICKY_CLEAR, oSTICKY_OVERFLOW/UNDERFLOW/INVALID      accumulated flags
module fmul_72bit_exception_pack #(
    parameter int DEPTH   = 2,
    parameter int EXP_MAX = 2047
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iDATA_VALID,
    output logic        oDATA_BUSY,
    input  logic        iDATA_SIGN,
    input  logic [12:0] iDATA_EXP,
    input  logic [60:0] iDATA_FRACT,
    input  logic        iDATA_EXCEPT_EXP_A0,
    input  logic        iDATA_EXCEPT_EXP_B0,
    input  logic        iDATA_EXCEPT_EXP_A1,
    input  logic        iDATA_EXCEPT_EXP_B1,
    input  logic        iDATA_EXCEPT_FRACT_A0,
    input  logic        iDATA_EXCEPT_FRACT_B0,
    output logic        oDATA_VALID,
    input  logic        iDATA_BUSY,
    output logic [71:0] oDATA_RESULT,
    output logic        oDATA_OVERFLOW,
    output logic        oDATA_UNDERFLOW,
    output logic        oDATA_INVALID,
    input  logic        iSTICKY_CLEAR,
    output logic        oSTICKY_OVERFLOW,
    output logic        oSTICKY_UNDERFLOW,
    output logic        oSTICKY_INVALID
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL = (AW + 1)'(DEPTH);
    localparam logic [71:0]  QNAN = 72'h7FF800000000000000;

    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic        inv;
        logic [71:0] res;
    } entry_t;

    // Special-operand resolution and exponent saturation, first match wins.
    function automatic entry_t pack_entry(
        input logic               sign,
        input logic signed [12:0] exp_s,
        input logic        [59:0] fract,
        input logic               a_exp0,
        input logic               a_exp1,
        input logic               a_fr0,
        input logic               b_exp0,
        input logic               b_exp1,
        input logic               b_fr0
    );
        entry_t e;
        logic   a_inf, a_nan, b_inf, b_nan;
        a_inf = a_exp1 & a_fr0;
        a_nan = a_exp1 & ~a_fr0;
        b_inf = b_exp1 & b_fr0;
        b_nan = b_exp1 & ~b_fr0;
        e = '0;
        if (a_nan | b_nan) begin
            e.res = QNAN;
        end else if ((a_inf & b_exp0) | (b_inf & a_exp0)) begin
            e.res = QNAN;
            e.inv = 1'b1;
        end else if (a_inf | b_inf) begin
            e.res = {sign, 11'h7FF, 60'h0};
        end else if (a_exp0 | b_exp0) begin
            // Denormal operands are flushed, so either zero class gives signed zero.
            e.res = {sign, 71'h0};
        end else if (exp_s <= 13'sd0) begin
            e.res = {sign, 71'h0};
            e.unf = 1'b1;
        end else if (int'(exp_s) >= EXP_MAX) begin
            e.res = {sign, 11'h7FF, 60'h0};
            e.ovf = 1'b1;
        end else begin
            e.res = {sign, exp_s[10:0], fract};
        end
        return e;
    endfunction

    // Hidden bit is implied by the packed format and is not stored.
    logic unused_hidden;
    assign unused_hidden = iDATA_FRACT[60];

    // ---- stage p0: classify and pack the incoming result ----
    entry_t entry_p0;
    logic   push_p0;

    assign entry_p0 = pack_entry(iDATA_SIGN, $signed(iDATA_EXP), iDATA_FRACT[59:0],
                                 iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_FRACT_A0,
                                 iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_B0);

    // ---- stage p1: output FIFO and sticky flags ----
    entry_t          fifo_mem_p1 [DEPTH];
    logic [AW-1:0]   wr_ptr_p1;
    logic [AW-1:0]   rd_ptr_p1;
    logic [AW:0]     count_p1;
    logic [AW:0]     count_next;
    logic            vld_p1;
    logic            pop_p1;
    logic            sticky_ovf_p1;
    logic            sticky_unf_p1;
    logic            sticky_inv_p1;
    entry_t          head_p1;

    assign vld_p1     = (count_p1 != '0);
    assign oDATA_BUSY = (count_p1 == FULL);
    assign push_p0    = iDATA_VALID & ~oDATA_BUSY;
    assign pop_p1     = vld_p1 & ~iDATA_BUSY;

    always_comb begin
        count_next = count_p1;
        if (push_p0 && !pop_p1) begin
            count_next = count_p1 + (AW + 1)'(1);
        end else if (!push_p0 && pop_p1) begin
            count_next = count_p1 - (AW + 1)'(1);
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_p1     <= '0;
            rd_ptr_p1     <= '0;
            count_p1      <= '0;
            sticky_ovf_p1 <= 1'b0;
            sticky_unf_p1 <= 1'b0;
            sticky_inv_p1 <= 1'b0;
        end else if (iRESET_SYNC) begin
            wr_ptr_p1     <= '0;
            rd_ptr_p1     <= '0;
            count_p1      <= '0;
            sticky_ovf_p1 <= 1'b0;
            sticky_unf_p1 <= 1'b0;
            sticky_inv_p1 <= 1'b0;
        end else begin
            if (push_p0) wr_ptr_p1 <= wr_ptr_p1 + AW'(1);
            if (pop_p1)  rd_ptr_p1 <= rd_ptr_p1 + AW'(1);
            count_p1 <= count_next;
            // A new flag in the same cycle as a clear takes precedence.
            sticky_ovf_p1 <= (sticky_ovf_p1 & ~iSTICKY_CLEAR) | (push_p0 & entry_p0.ovf);
            sticky_unf_p1 <= (sticky_unf_p1 & ~iSTICKY_CLEAR) | (push_p0 & entry_p0.unf);
            sticky_inv_p1 <= (sticky_inv_p1 & ~iSTICKY_CLEAR) | (push_p0 & entry_p0.inv);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge iCLOCK) begin
        if (push_p0) fifo_mem_p1[wr_ptr_p1] <= entry_p0;
    end

    assign head_p1 = fifo_mem_p1[rd_ptr_p1];

    assign oDATA_VALID       = vld_p1;
    assign oDATA_RESULT      = vld_p1 ? head_p1.res : 72'h0;
    assign oDATA_OVERFLOW    = vld_p1 & head_p1.ovf;
    assign oDATA_UNDERFLOW   = vld_p1 & head_p1.unf;
    assign oDATA_INVALID     = vld_p1 & head_p1.inv;
    assign oSTICKY_OVERFLOW  = sticky_ovf_p1;
    assign oSTICKY_UNDERFLOW = sticky_unf_p1;
    assign oSTICKY_INVALID   = sticky_inv_p1;

endmodule

// File: tb/tb_fmul_72bit_exception_pack.sv
// Testbench for fmul_72bit_exception_pack: directed vectors with
// hand-computed packed results, flags, handshake and reset behaviour.
module tb_fmul_72bit_exception_pack;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iRESET_SYNC;
    logic        iDATA_VALID;
    logic        oDATA_BUSY;
    logic        iDATA_SIGN;
    logic [12:0] iDATA_EXP;
    logic [60:0] iDATA_FRACT;
    logic        iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0;
    logic        iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_EXP_B1;
    logic        iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0;
    logic        oDATA_VALID;
    logic        iDATA_BUSY;
    logic [71:0] oDATA_RESULT;
    logic        oDATA_OVERFLOW, oDATA_UNDERFLOW, oDATA_INVALID;
    logic        iSTICKY_CLEAR;
    logic        oSTICKY_OVERFLOW, oSTICKY_UNDERFLOW, oSTICKY_INVALID;

    int n_total = 0;
    int n_pass  = 0;

    // Exception class vectors: {A_EXP0, A_EXP1, A_FRACT0, B_EXP0, B_EXP1, B_FRACT0}
    localparam logic [5:0] X_NONE   = 6'b000_000;
    localparam logic [5:0] X_AINF_B0 = 6'b011_100;
    localparam logic [5:0] X_ANAN_B0 = 6'b010_100;
    localparam logic [5:0] X_AINF   = 6'b011_000;
    localparam logic [5:0] X_B0     = 6'b000_100;
    localparam logic [60:0] FR1     = 61'h1000000000000000;

    fmul_72bit_exception_pack #(.DEPTH(2), .EXP_MAX(2047)) dut (
        .iCLOCK               (iCLOCK),
        .inRESET              (inRESET),
        .iRESET_SYNC          (iRESET_SYNC),
        .iDATA_VALID          (iDATA_VALID),
        .oDATA_BUSY           (oDATA_BUSY),
        .iDATA_SIGN           (iDATA_SIGN),
        .iDATA_EXP            (iDATA_EXP),
        .iDATA_FRACT          (iDATA_FRACT),
        .iDATA_EXCEPT_EXP_A0  (iDATA_EXCEPT_EXP_A0),
        .iDATA_EXCEPT_EXP_B0  (iDATA_EXCEPT_EXP_B0),
        .iDATA_EXCEPT_EXP_A1  (iDATA_EXCEPT_EXP_A1),
        .iDATA_EXCEPT_EXP_B1  (iDATA_EXCEPT_EXP_B1),
        .iDATA_EXCEPT_FRACT_A0(iDATA_EXCEPT_FRACT_A0),
        .iDATA_EXCEPT_FRACT_B0(iDATA_EXCEPT_FRACT_B0),
        .oDATA_VALID          (oDATA_VALID),
        .iDATA_BUSY           (iDATA_BUSY),
        .oDATA_RESULT         (oDATA_RESULT),
        .oDATA_OVERFLOW       (oDATA_OVERFLOW),
        .oDATA_UNDERFLOW      (oDATA_UNDERFLOW),
        .oDATA_INVALID        (oDATA_INVALID),
        .iSTICKY_CLEAR        (iSTICKY_CLEAR),
        .oSTICKY_OVERFLOW     (oSTICKY_OVERFLOW),
        .oSTICKY_UNDERFLOW    (oSTICKY_UNDERFLOW),
        .oSTICKY_INVALID      (oSTICKY_INVALID)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check(tag, 72'({oDATA_OVERFLOW, oDATA_UNDERFLOW, oDATA_INVALID}), 72'(exp));
    endtask

    task automatic check_sticky(input string tag, input logic [2:0] exp);
        check(tag, 72'({oSTICKY_OVERFLOW, oSTICKY_UNDERFLOW, oSTICKY_INVALID}), 72'(exp));
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, 72'(obs), 72'(exp));
    endtask

    task automatic drive(input logic v, input logic s, input logic [12:0] e,
                         input logic [60:0] f, input logic [5:0] x);
        iDATA_VALID = v;
        iDATA_SIGN  = s;
        iDATA_EXP   = e;
        iDATA_FRACT = f;
        {iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_FRACT_A0,
         iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_B0} = x;
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    // Push one result into an empty, unstalled FIFO, check the head one cycle
    // later, then let it drain.
    task automatic single(input string tag, input logic s, input logic [12:0] e,
                          input logic [60:0] f, input logic [5:0] x,
                          input logic [71:0] exp_res, input logic [2:0] exp_fl);
        drive(1'b1, s, e, f, x);
        #1;
        check_bit({tag, "_nobypass"}, oDATA_VALID, 1'b0);
        tick();
        check_bit({tag, "_valid"}, oDATA_VALID, 1'b1);
        check({tag, "_result"}, oDATA_RESULT, exp_res);
        check_flags({tag, "_flags"}, exp_fl);
        drive(1'b0, 1'b0, 13'h0, 61'h0, X_NONE);
        tick();
        check_bit({tag, "_drained"}, oDATA_VALID, 1'b0);
    endtask

    initial begin
        inRESET       = 1'b0;
        iRESET_SYNC   = 1'b0;
        iDATA_BUSY    = 1'b0;
        iSTICKY_CLEAR = 1'b0;
        drive(1'b0, 1'b0, 13'h0, 61'h0, X_NONE);
        #12;
        check_bit("rst_valid", oDATA_VALID, 1'b0);
        check_bit("rst_busy", oDATA_BUSY, 1'b0);
        check("rst_result", oDATA_RESULT, 72'h0);
        check_flags("rst_flags", 3'b000);
        check_sticky("rst_sticky", 3'b000);
        inRESET = 1'b1;
        tick();

        // Normal results, including the exponent boundaries just inside range.
        single("normal", 1'b0, 13'h3FF, FR1, X_NONE, 72'h3FF000000000000000, 3'b000);
        single("fract", 1'b0, 13'h400, 61'h123456789ABCDEF0, X_NONE,
               72'h40023456789ABCDEF0, 3'b000);
        single("exp_2046", 1'b0, 13'h07FE, FR1, X_NONE, 72'h7FE000000000000000, 3'b000);
        single("exp_1", 1'b1, 13'h0001, FR1, X_NONE, 72'h801000000000000000, 3'b000);
        check_sticky("sticky_clean", 3'b000);

        // Overflow and underflow.
        single("ovf", 1'b1, 13'h07FF, FR1, X_NONE, 72'hFFF000000000000000, 3'b100);
        check_sticky("sticky_ovf", 3'b100);
        single("unf_neg", 1'b1, 13'h1FFE, FR1, X_NONE, 72'h800000000000000000, 3'b010);
        single("unf_zero", 1'b0, 13'h0000, FR1, X_NONE, 72'h000000000000000000, 3'b010);
        check_sticky("sticky_ovf_unf", 3'b110);

        // Special operands and their priority over exponent checks.
        single("inf_x_zero", 1'b1, 13'h3FF, FR1, X_AINF_B0, 72'h7FF800000000000000, 3'b001);
        single("nan", 1'b1, 13'h3FF, FR1, X_ANAN_B0, 72'h7FF800000000000000, 3'b000);
        single("inf", 1'b1, 13'h3FF, FR1, X_AINF, 72'hFFF000000000000000, 3'b000);
        single("zero_over_ovf", 1'b1, 13'h07FF, FR1, X_B0, 72'h800000000000000000, 3'b000);
        check_sticky("sticky_all", 3'b111);

        iSTICKY_CLEAR = 1'b1;
        tick();
        iSTICKY_CLEAR = 1'b0;
        check_sticky("sticky_cleared", 3'b000);

        // Downstream stall: two accepts fill the FIFO, third input is held.
        iDATA_BUSY = 1'b1;
        drive(1'b1, 1'b0, 13'h100, FR1, X_NONE);
        tick();
        check_bit("bp_busy_1", oDATA_BUSY, 1'b0);
        drive(1'b1, 1'b0, 13'h101, FR1, X_NONE);
        tick();
        check_bit("bp_busy_2", oDATA_BUSY, 1'b1);
        drive(1'b1, 1'b0, 13'h102, FR1, X_NONE);
        tick();
        check_bit("bp_busy_held", oDATA_BUSY, 1'b1);
        check("bp_head_1", oDATA_RESULT, 72'h100000000000000000);
        iDATA_BUSY = 1'b0;
        tick();
        check_bit("bp_busy_drop", oDATA_BUSY, 1'b0);
        check("bp_head_2", oDATA_RESULT, 72'h101000000000000000);
        tick();
        drive(1'b0, 1'b0, 13'h0, 61'h0, X_NONE);
        check("bp_head_3", oDATA_RESULT, 72'h102000000000000000);
        check_bit("bp_valid_3", oDATA_VALID, 1'b1);
        tick();
        check_bit("bp_empty", oDATA_VALID, 1'b0);

        // Synchronous clear discards a full FIFO and the sticky flags.
        iDATA_BUSY = 1'b1;
        drive(1'b1, 1'b0, 13'h07FF, FR1, X_NONE);
        tick();
        drive(1'b1, 1'b0, 13'h200, FR1, X_NONE);
        tick();
        drive(1'b0, 1'b0, 13'h0, 61'h0, X_NONE);
        check_bit("sr_full", oDATA_BUSY, 1'b1);
        check_sticky("sr_sticky_pre", 3'b100);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        check_bit("sr_valid", oDATA_VALID, 1'b0);
        check_bit("sr_busy", oDATA_BUSY, 1'b0);
        check("sr_result", oDATA_RESULT, 72'h0);
        check_sticky("sr_sticky", 3'b000);

        // Sticky set wins over a concurrent clear.
        iDATA_BUSY = 1'b0;
        iSTICKY_CLEAR = 1'b1;
        drive(1'b1, 1'b0, 13'h07FF, FR1, X_NONE);
        tick();
        iSTICKY_CLEAR = 1'b0;
        drive(1'b0, 1'b0, 13'h0, 61'h0, X_NONE);
        check_sticky("set_wins", 3'b100);
        check_flags("set_wins_flags", 3'b100);
        tick();

        // Asynchronous reset takes effect without a clock edge.
        iDATA_BUSY = 1'b1;
        drive(1'b1, 1'b0, 13'h3FF, FR1, X_NONE);
        tick();
        drive(1'b0, 1'b0, 13'h0, 61'h0, X_NONE);
        check_bit("ar_pre_valid", oDATA_VALID, 1'b1);
        #2;
        inRESET = 1'b0;
        #1;
        check_bit("ar_valid", oDATA_VALID, 1'b0);
        check("ar_result", oDATA_RESULT, 72'h0);
        check_sticky("ar_sticky", 3'b000);
        inRESET = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
